// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op codes, FSM states, default width.
package mips_muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the MDU datapath: radix-2 shift-add (multiply) or restoring
// shift-subtract (divide) on a 2*WIDTH accumulator.
module mips_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, b} : '0);
    // partial is the remainder shifted left with the next dividend bit appended
    partial = acc_in[2*WIDTH-1:WIDTH-1];
    diff    = partial[WIDTH-1:0] - b;
    if (div_mode) begin
      if (partial >= {1'b0, b}) begin
        acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// MIPS multiply/divide unit with HI/LO registers. Define MIPS_MULDIV_FAST_MUL_EN
// to replace the iterative multiply with a single-cycle multiplier.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output state_e           state_dbg
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_reg;
  logic               is_div;
  logic               neg_prod;
  logic               neg_rem;
  logic               div_zero;

  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [2*WIDTH-1:0] step_out;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = op_signed & srca[WIDTH-1];
    b_neg     = op_signed & srcb[WIDTH-1];
    a_mag     = a_neg ? -srca : srca;
    b_mag     = b_neg ? -srcb : srcb;
  end

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (state == ST_DIV),
    .acc_in   (acc),
    .b        (b_reg),
    .acc_out  (step_out)
  );

`ifdef MIPS_MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, b_reg};
`endif

  // Sign correction: neg_prod doubles as the quotient sign, neg_rem follows the dividend.
  always_comb begin
    prod_fix = neg_prod ? -acc : acc;
    quo_fix  = neg_prod ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // Handshake: start is sampled only in IDLE and only when flush is low; while busy
  // the issuing stage must hold off, and any start seen then is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      b_reg    <= '0;
      is_div   <= 1'b0;
      neg_prod <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state    <= (op[1]) ? ST_DIV : ST_MUL;
                is_div   <= op[1];
                cnt      <= CNT_W'(WIDTH - 1);
                acc      <= {{WIDTH{1'b0}}, a_mag};
                b_reg    <= b_mag;
                neg_prod <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (srcb == '0);
              end
              OP_MTHI: hi <= srca;
              OP_MTLO: lo <= srca;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
`ifdef MIPS_MULDIV_FAST_MUL_EN
            acc   <= fast_prod;
            state <= ST_FIX;
`else
            acc <= step_out;
            if (cnt == '0) state <= ST_FIX;
            else           cnt   <= cnt - 1'b1;
`endif
          end
        end
        ST_DIV: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            acc <= step_out;
            if (cnt == '0) state <= ST_FIX;
            else           cnt   <= cnt - 1'b1;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= div_zero ? '1 : quo_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
